// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ps2_pkg
// Description : Shared definitions for the PS/2 host transmitter and the
//               scancode receiver. Contents: the transmitter state encoding,
//               the clock glitch filter length, common keyboard command
//               bytes and the odd-parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Host transmitter states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_XFER    = 3'd3,
    ST_ACK     = 3'd4,
    ST_WAIT    = 3'd5
  } ps2_tx_state_t;

  // Number of consecutive equal samples needed to accept a ps2 clock level
  localparam int PS2_FILTER_LEN = 8;

  // Common keyboard command bytes
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  // PS/2 frames carry odd parity: data bits plus parity hold an odd count of ones
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_clk_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_clk_filter
// Description : Glitch filter for the ps2 clock line plus falling-edge pulse.
//               The filtered level changes only after PS2_FILTER_LEN equal
//               samples; otherwise the previous level is held. Shared with
//               the receiver so both ends see identical edges.
// Ports       : clock    - system clock
//               reset_n  - asynchronous active-low reset
//               ce       - clock enable, sampling happens only when 1
//               ps2_clk  - raw ps2 clock line level
//               clk_filt - filtered clock level
//               fall     - one-ce-tick pulse on a filtered 1->0 transition
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_clk_filter
  import ps2_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic ce,
  input  logic ps2_clk,
  output logic clk_filt,
  output logic fall
);

  logic [PS2_FILTER_LEN-1:0] r_shift;
  logic [PS2_FILTER_LEN-1:0] w_shift_next;
  logic                      r_filt;
  logic                      r_fall;

  assign w_shift_next = {r_shift[PS2_FILTER_LEN-2:0], ps2_clk};

  // Reset to an all-high history so an idle line never produces a fall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '1;
      r_filt  <= 1'b1;
      r_fall  <= 1'b0;
    end else if (ce) begin
      r_shift <= w_shift_next;
      r_fall  <= 1'b0;
      if (&w_shift_next) begin
        r_filt <= 1'b1;
      end else if (~|w_shift_next) begin
        r_filt <= 1'b0;
        // Pulse only when the filtered level was still high
        r_fall <= r_filt;
      end
    end
  end

  assign clk_filt = r_filt;
  assign fall     = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : Host-to-device PS/2 transmitter. Inhibits the bus, issues a
//               request-to-send, shifts one command byte plus odd parity out
//               on device clock falls, checks the device ACK and releases the
//               open-drain lines. Reports completion with done/error.
// Ports       : clock, reset_n, ce       - clock, async low reset, enable
//               ps2[1:0]                 - line sense ([0] clock, [1] data)
//               ps2_clk_oe, ps2_dat_oe   - open-drain pull-low enables
//               tx_valid, tx_data        - command byte handshake in
//               tx_ready                 - idle, ready to accept a byte
//               busy                     - transfer in progress
//               done, error              - completion pulse and status
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_TICKS = 128,
  parameter int TIMEOUT_TICKS = 16384
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ce,
  input  logic [1:0] ps2,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // One tick counter serves both the inhibit interval and the edge timeout
  localparam int INH_W = $clog2(INHIBIT_TICKS);
  localparam int TMO_W = $clog2(TIMEOUT_TICKS);
  localparam int CNT_W = (INH_W > TMO_W) ? INH_W : TMO_W;

  localparam logic [CNT_W-1:0] c_inh_last = CNT_W'(INHIBIT_TICKS - 1);
  localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  ps2_tx_state_t    r_state;
  logic [7:0]       r_data;
  logic             r_parity;
  logic [3:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_oe;
  logic             r_dat_oe;
  logic             r_done;
  logic             r_error;
  logic             r_dat;

  logic             w_filt;
  logic             w_fall;
  logic             w_timeout;

  ps2_clk_filter u_clk_filter (
    .clock    (clock),
    .reset_n  (reset_n),
    .ce       (ce),
    .ps2_clk  (ps2[0]),
    .clk_filt (w_filt),
    .fall     (w_fall)
  );

  // A fall on the last allowed tick still counts as a live device
  assign w_timeout = (r_cnt == c_tmo_last) && !w_fall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_data   <= '0;
      r_parity <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_dat    <= 1'b1;
    end else if (ce) begin
      r_dat  <= ps2[1];
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_valid) begin
            r_data   <= tx_data;
            r_parity <= odd_parity(tx_data);
            r_cnt    <= '0;
            r_error  <= 1'b0;
            r_state  <= ST_INHIBIT;
          end
        end

        // Clock is held low here, so any device fall is ignored.
        ST_INHIBIT: begin
          r_clk_oe <= 1'b1;
          if (r_cnt == c_inh_last) begin
            r_dat_oe <= 1'b1;
            r_cnt    <= '0;
            r_state  <= ST_REQ;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        default: begin
          if (w_timeout) begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_error  <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            if (w_fall) begin
              r_cnt <= '0;
            end else if (r_cnt != '1) begin
              r_cnt <= r_cnt + c_cnt_one;
            end
            case (r_state)
              ST_REQ: begin
                r_clk_oe <= 1'b0;
                r_dat_oe <= 1'b1;
                r_idx    <= '0;
                r_state  <= ST_XFER;
              end
              ST_XFER: begin
                if (w_fall) begin
                  if (r_idx < 4'd8) begin
                    r_dat_oe <= ~r_data[r_idx[2:0]];
                  end else if (r_idx == 4'd8) begin
                    r_dat_oe <= ~r_parity;
                  end else begin
                    r_dat_oe <= 1'b0;
                    r_state  <= ST_ACK;
                  end
                  r_idx <= r_idx + 4'd1;
                end
              end
              ST_ACK: begin
                if (w_fall) begin
                  // Device pulls data low to acknowledge
                  r_error <= r_dat;
                  r_state <= ST_WAIT;
                end
              end
              ST_WAIT: begin
                if (w_filt && r_dat) begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
                end
              end
              default: begin
                r_clk_oe <= 1'b0;
                r_dat_oe <= 1'b0;
                r_state  <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;
  assign tx_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Directed self-checking bench for ps2_host_tx with a simple
//               open-drain PS/2 device model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INHIBIT_TICKS = 128;
  localparam int TIMEOUT_TICKS = 16384;

  logic       clock       = 1'b0;
  logic       reset_n     = 1'b0;
  logic       ce          = 1'b1;
  logic       tx_valid    = 1'b0;
  logic [7:0] tx_data     = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic [1:0] ps2;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;

  // Wired-AND open-drain bus with pull-ups
  assign ps2 = {~(ps2_dat_oe | dev_dat_low), ~(ps2_clk_oe | dev_clk_low)};

  always #5 clock = ~clock;

  ps2_host_tx #(
    .INHIBIT_TICKS (INHIBIT_TICKS),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ce         (ce),
    .ps2        (ps2),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for a single accepting edge
  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick(1);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  // Device side of one frame: 11 clock falls, line sampled late in each low
  // phase. bits[7:0] data, bits[8] parity, bits[9] stop.
  task automatic device_frame(input logic ack, input logic glitch, input logic inject,
                              input int abort_fall, output logic [9:0] bits);
    int n;
    bits = '0;
    n = 0;
    while (!(busy === 1'b1 && ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && n < 1000) begin
      tick(1);
      n++;
    end
    check("req_seen", {31'd0, (n < 1000)}, 32'd1);
    tick(30);
    check("start_bit_low", {31'd0, ps2[1]}, 32'd0);
    if (glitch) begin
      dev_clk_low = 1'b1;
      tick(3);
      dev_clk_low = 1'b0;
      tick(15);
    end
    for (int f = 1; f <= 11; f++) begin
      if (inject && f == 3) begin
        tx_data  = 8'h55;
        tx_valid = 1'b1;
      end
      if (inject && f == 6) tx_valid = 1'b0;
      dev_clk_low = 1'b1;
      if (f == 11 && ack) dev_dat_low = 1'b1;
      if (f == abort_fall) begin
        tick(15);
        check("abort_dat_oe_driven", {31'd0, ps2_dat_oe}, 32'd1);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("abort_clk_oe_released", {31'd0, ps2_clk_oe}, 32'd0);
        check("abort_dat_oe_released", {31'd0, ps2_dat_oe}, 32'd0);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check("abort_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        return;
      end
      tick(20);
      if (f <= 10) bits[f-1] = ps2[1];
      if (inject && f == 4) check("busy_ignores_valid", {31'd0, tx_ready}, 32'd0);
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      if (f < 11) tick(20);
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int          n;
    int          cnt;
    int          dat_at;
    logic [9:0]  bits;

    // Reset state
    reset_n = 1'b0;
    tick(3);
    check("rst_clk_oe",   {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_dat_oe",   {31'd0, ps2_dat_oe}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready},   32'd1);
    check("rst_busy",     {31'd0, busy},       32'd0);
    check("rst_done",     {31'd0, done},       32'd0);
    check("rst_error",    {31'd0, error},      32'd0);
    reset_n = 1'b1;
    tick(2);

    // Normal send of 0xED with inhibit timing measurement
    start_tx(CMD_SET_LEDS);
    check("accept_busy",     {31'd0, busy},     32'd1);
    check("accept_tx_ready", {31'd0, tx_ready}, 32'd0);
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    cnt    = 0;
    dat_at = 0;
    while (ps2_clk_oe === 1'b1 && cnt < 1000) begin
      cnt++;
      if (ps2_dat_oe === 1'b1 && dat_at == 0) dat_at = cnt;
      tick(1);
    end
    check("inhibit_len",       cnt,    INHIBIT_TICKS);
    check("start_on_last_tick", dat_at, INHIBIT_TICKS);
    check("start_held",        {31'd0, ps2_dat_oe}, 32'd1);
    device_frame(1'b1, 1'b0, 1'b0, 0, bits);
    check("ed_data",   bits[7:0], 32'hED);
    check("ed_parity", bits[8],   32'd1);
    check("ed_stop",   bits[9],   32'd1);
    wait_done(100, n);
    check("ed_error",    {31'd0, error},      32'd0);
    check("ed_tx_ready", {31'd0, tx_ready},   32'd1);
    check("ed_clk_rel",  {31'd0, ps2_clk_oe}, 32'd0);
    check("ed_dat_rel",  {31'd0, ps2_dat_oe}, 32'd0);
    tick(1);
    check("ed_done_pulse", {31'd0, done}, 32'd0);

    // No ACK on 0xF4
    tick(5);
    start_tx(CMD_ENABLE);
    device_frame(1'b0, 1'b0, 1'b0, 0, bits);
    check("f4_data",   bits[7:0], 32'hF4);
    check("f4_parity", bits[8],   32'd0);
    check("f4_stop",   bits[9],   32'd1);
    wait_done(100, n);
    check("noack_error",   {31'd0, error},      32'd1);
    check("noack_clk_rel", {31'd0, ps2_clk_oe}, 32'd0);
    check("noack_dat_rel", {31'd0, ps2_dat_oe}, 32'd0);
    tick(5);
    check("noack_error_held", {31'd0, error}, 32'd1);

    // Glitch on clock plus tx_valid 0x55 while busy
    start_tx(8'h81);
    check("accept_clears_error", {31'd0, error}, 32'd0);
    device_frame(1'b1, 1'b1, 1'b1, 0, bits);
    check("glitch_data",   bits[7:0], 32'h81);
    check("glitch_parity", bits[8],   32'd1);
    check("glitch_stop",   bits[9],   32'd1);
    wait_done(100, n);
    check("glitch_error", {31'd0, error}, 32'd0);
    tick(5);
    check("no_second_accept", {31'd0, busy}, 32'd0);

    // Reset during bit 4
    start_tx(CMD_SET_LEDS);
    device_frame(1'b1, 1'b0, 1'b0, 5, bits);
    tick(5);

    // Timeout: device never clocks after the request
    start_tx(CMD_ECHO);
    wait_done(20000, n);
    check("timeout_ticks",     n, INHIBIT_TICKS + TIMEOUT_TICKS);
    check("timeout_error",     {31'd0, error},      32'd1);
    check("timeout_clk_rel",   {31'd0, ps2_clk_oe}, 32'd0);
    check("timeout_dat_rel",   {31'd0, ps2_dat_oe}, 32'd0);
    check("timeout_tx_ready",  {31'd0, tx_ready},   32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
